// File: rtl/input_debouncer.sv
// Switch/button conditioner: N-flop synchronizer feeding a counter-qualified
// 4-state FSM, with a saturating count of rejected glitches for debug.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_i,
  output logic                level_o,
  output logic                busy_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE_LO   = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  logic [GLITCH_W-1:0]    glitch_reg, glitch_next;
  logic [GLITCH_W-1:0]    glitch_inc;

  // Stage 0 captures the raw input; s is the last, metastability-settled stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // Saturating increment: the counter holds at all-ones instead of wrapping.
  assign glitch_inc = (glitch_reg == '1) ? glitch_reg : glitch_reg + GLITCH_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE_LO;
      cnt_reg    <= '0;
      level_reg  <= 1'b0;
      glitch_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      level_reg  <= level_next;
      glitch_reg <= glitch_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    level_next  = level_reg;
    glitch_next = glitch_reg;
    case (state_reg)
      IDLE_LO: begin
        if (s) begin
          state_next = WAIT_HI;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_next  = IDLE_LO;
          cnt_next    = '0;
          glitch_next = glitch_inc;
        end else if (cnt_reg == CNT_DONE) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
          level_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_next = WAIT_LO;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_next  = STABLE_HI;
          cnt_next    = '0;
          glitch_next = glitch_inc;
        end else if (cnt_reg == CNT_DONE) begin
          state_next = IDLE_LO;
          cnt_next   = '0;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE_LO;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign level_o      = level_reg;
  assign busy_o       = (state_reg == WAIT_HI) || (state_reg == WAIT_LO);
  assign glitch_cnt_o = glitch_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus randomized bouncing input
// compared against a run-length reference model of the debounce rules.
module tb_input_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic       level, busy, level_s, busy_s;
  logic [7:0] gcnt;
  logic [1:0] gcnt_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(3), .GLITCH_W(8)) dut (
    .clk(clk), .reset(reset), .btn_i(btn),
    .level_o(level), .busy_o(busy), .glitch_cnt_o(gcnt)
  );

  input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(3), .GLITCH_W(2)) dut_sat (
    .clk(clk), .reset(reset), .btn_i(btn),
    .level_o(level_s), .busy_o(busy_s), .glitch_cnt_o(gcnt_s)
  );

  // Reference model: input delayed by SYNC edges, then the output level flips
  // once the delayed input has differed from it on DEB+1 consecutive edges.
  // A run that ends early counts as one glitch.
  logic [SYNC-1:0] m_pipe = '0;
  int              m_run = 0;
  logic            m_level = 1'b0;
  int              m_glitch = 0;
  logic            m_busy;
  int              m_g8, m_g2;

  always @(posedge clk) begin
    if (reset) begin
      m_pipe   = '0;
      m_run    = 0;
      m_level  = 1'b0;
      m_glitch = 0;
    end else begin
      if (m_pipe[SYNC-1] != m_level) begin
        m_run = m_run + 1;
        if (m_run == DEB + 1) begin
          m_level = m_pipe[SYNC-1];
          m_run   = 0;
        end
      end else begin
        if (m_run > 0) m_glitch = m_glitch + 1;
        m_run = 0;
      end
      m_pipe = {m_pipe[SYNC-2:0], btn};
    end
  end

  assign m_busy = (m_run > 0);
  assign m_g8   = (m_glitch > 255) ? 255 : m_glitch;
  assign m_g2   = (m_glitch > 3) ? 3 : m_glitch;

  task automatic test_reset();
    btn = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (level !== 1'b0) begin failures++; $display("FAIL reset_level got=%b exp=0", level); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (gcnt !== 8'd0) begin failures++; $display("FAIL reset_glitch got=%0d exp=0", gcnt); end
    @(negedge clk);
    reset = 1'b0;
    // Input held high through reset release must be re-qualified.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (level !== m_level || busy !== m_busy) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got level=%b busy=%b exp level=%b busy=%b",
                 i, level, busy, m_level, m_busy);
      end
    end
    checks++;
    if (level !== 1'b1) begin failures++; $display("FAIL reset_release_final got=%b exp=1", level); end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (level !== 1'b0) begin failures++; $display("FAIL press_pre_level got=%b exp=0", level); end
    btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== (i >= 2 && i <= 5)) begin
        failures++;
        $display("FAIL press_busy edge=k+%0d got=%b exp=%b", i, busy, (i >= 2 && i <= 5));
      end
      checks++;
      if (level !== (i >= 6)) begin
        failures++;
        $display("FAIL press_level edge=k+%0d got=%b exp=%b", i, level, (i >= 6));
      end
    end
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    int   rises = 0;
    logic prev;
    btn = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    prev = level;
    for (int r = 0; r < 3; r++) begin
      btn = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (level && !prev) rises++;
        prev = level;
      end
      btn = 1'b0;
      @(negedge clk);
      if (level && !prev) rises++;
      prev = level;
    end
    btn = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (level && !prev) rises++;
      prev = level;
    end
    checks++;
    if (rises !== 1) begin failures++; $display("FAIL bounce_rises got=%0d exp=1", rises); end
    checks++;
    if (gcnt !== 8'd3) begin failures++; $display("FAIL bounce_glitch got=%0d exp=3", gcnt); end
    checks++;
    if (level !== 1'b1) begin failures++; $display("FAIL bounce_level got=%b exp=1", level); end
    $display("test_bounce done rises=%0d glitches=%0d", rises, gcnt);
  endtask

  task automatic test_clean_release();
    btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (level !== (i < 6)) begin
        failures++;
        $display("FAIL release_level edge=k+%0d got=%b exp=%b", i, level, (i < 6));
      end
    end
    checks++;
    if (gcnt !== 8'd3) begin failures++; $display("FAIL release_glitch got=%0d exp=3", gcnt); end
    $display("test_clean_release done");
  endtask

  task automatic test_reset_mid();
    btn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || level !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre got busy=%b level=%b exp busy=1 level=0", busy, level);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (level !== 1'b0 || busy !== 1'b0 || gcnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset got level=%b busy=%b glitch=%0d exp 0/0/0", level, busy, gcnt);
    end
    reset = 1'b0;
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (level !== 1'b0) begin failures++; $display("FAIL mid_no_pulse cyc=%0d got=%b exp=0", i, level); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_saturation();
    btn = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    for (int n = 1; n <= 5; n++) begin
      btn = 1'b1;
      @(negedge clk);
      btn = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (gcnt_s !== 2'((n < 3) ? n : 3)) begin
        failures++;
        $display("FAIL sat_glitch n=%0d got=%0d exp=%0d", n, gcnt_s, (n < 3) ? n : 3);
      end
      checks++;
      if (gcnt !== 8'(n)) begin failures++; $display("FAIL sat_wide_glitch n=%0d got=%0d exp=%0d", n, gcnt, n); end
    end
    $display("test_saturation done glitch2=%0d glitch8=%0d", gcnt_s, gcnt);
  endtask

  task automatic test_random();
    int hold;
    btn = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3000; c += hold) begin
      hold = $urandom_range(1, 9);
      btn = $urandom_range(0, 1) == 1;
      for (int h = 0; h < hold; h++) begin
        reset = ($urandom_range(0, 299) == 0);
        @(negedge clk);
        checks++;
        if (level !== m_level || busy !== m_busy || gcnt !== 8'(m_g8) ||
            level_s !== m_level || busy_s !== m_busy || gcnt_s !== 2'(m_g2)) begin
          failures++;
          $display("FAIL random cyc=%0d got lvl=%b busy=%b g=%0d lvl2=%b busy2=%b g2=%0d exp lvl=%b busy=%b g=%0d g2=%0d",
                   c + h, level, busy, gcnt, level_s, busy_s, gcnt_s, m_level, m_busy, m_g8, m_g2);
        end
      end
    end
    reset = 1'b0;
    $display("test_random done model_glitches=%0d", m_glitch);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_clean_release();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
